// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared FSM state type and width helper for the term accumulator
package accum_pkg;

   // ACCUM absorbs terms, DONE presents a finished frame until it is taken
   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   // Sum width that cannot overflow for nterms operands of n bits each
   function automatic int acc_width(input int n, input int nterms);
      return n + $clog2(nterms);
   endfunction

endpackage

// File: rtl/nbit_adder.sv
// rtl/nbit_adder.sv - unsigned n-bit adder with carry-out on the top bit
module nbit_adder #(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n:0]   s
);

   assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/term_accumulator.sv
// rtl/term_accumulator.sv - sums up to NTERMS unsigned terms per frame and hands out one result
module term_accumulator
   import accum_pkg::*;
#(
   parameter int N      = 4,
   parameter int NTERMS = 4,
   localparam int W     = acc_width(N, NTERMS),
   localparam int CW    = $clog2(NTERMS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] out_count
);

   state_t        state;
   logic [W-1:0]  acc;
   logic [CW-1:0] cnt;
   logic [W:0]    sum_full;
   logic [W-1:0]  sum;
   logic          unused_carry;
   logic [CW-1:0] cnt_next;
   logic          xfer;
   logic          close;

   // The only adder in the block: running sum plus the zero-extended term
   nbit_adder #(.n(W)) u_adder (
      .a (acc),
      .b ({{(W-N){1'b0}}, in_data}),
      .s (sum_full)
   );

   // Carry-out can never be set since NTERMS maximal terms still fit in W bits
   assign sum          = sum_full[W-1:0];
   assign unused_carry = sum_full[W];

   assign cnt_next = cnt + CW'(1);
   assign xfer     = in_valid & in_ready;
   // A full frame and an early in_last close the frame in the same single event
   assign close    = (cnt == CW'(NTERMS - 1)) || in_last;

   // Frame FSM with registered handshake flags; reset wins over any transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_count <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (xfer) begin
                  acc <= sum;
                  cnt <= cnt_next;
                  if (close) begin
                     out_data  <= sum;
                     out_count <= cnt_next;
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= ACCUM;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ACCUM;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_term_accumulator.sv
// tb/tb_term_accumulator.sv - scoreboard bench for term_accumulator with N=4, NTERMS=4
module tb_term_accumulator;

   localparam int N      = 4;
   localparam int NTERMS = 4;
   localparam int W      = 6;
   localparam int CW     = 3;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;

   typedef struct {
      int data;
      int count;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   term_accumulator #(.N(N), .NTERMS(NTERMS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result monitor: every handshake pops the oldest expected frame
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got result data=%0d count=%0d, required no result", out_data, out_count);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (out_data !== W'(e.data)) begin
               n_bad++;
               $display("FAIL sb_data: got %0d, required %0d", out_data, e.data);
            end
            n_cmp++;
            if (out_count !== CW'(e.count)) begin
               n_bad++;
               $display("FAIL sb_count: got %0d, required %0d", out_count, e.count);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Offer one term and hold it until the DUT accepts it; returns at posedge+1
   task automatic put(input logic [N-1:0] d, input logic l);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL put_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Send a frame, pushing its expected result; optional idle gaps carry junk data
   task automatic send_frame(input int vals[$], input bit use_last, input int maxgap, input bit chk);
      exp_t e;
      e.data  = 0;
      e.count = vals.size();
      foreach (vals[i]) e.data += vals[i];
      sb.push_back(e);
      foreach (vals[i]) begin
         if (i > 0 && maxgap > 0) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            in_valid = 1'b0;
            in_data  = 4'hF;
            in_last  = 1'b1;
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
            in_last = 1'b0;
         end
         put(N'(vals[i]), use_last && (i == vals.size() - 1));
      end
      if (chk) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency: out_valid=%0b one cycle after closing transfer, required 1", out_valid);
         end
         @(posedge clk);
         #1;
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_handshake: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
      end
      n_cmp++;
      if (out_data !== '0 || out_count !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: data=%0d count=%0d, required 0/0", out_data, out_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_frame();
      send_frame('{15, 15, 15, 15}, 1'b0, 0, 1'b1);
   endtask

   task automatic test_early_last();
      send_frame('{3, 5}, 1'b1, 0, 1'b1);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_frame('{1, 1}, 1'b1, 0, 1'b0);
      in_valid = 1'b1;
      in_data  = 4'hF;
      in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_flags cycle %0d: out_valid=%0b in_ready=%0b, required 1/0", c, out_valid, in_ready);
         end
         n_cmp++;
         if (out_data !== 6'd2 || out_count !== 3'd2) begin
            n_bad++;
            $display("FAIL hold_data cycle %0d: data=%0d count=%0d, required 2/2", c, out_data, out_count);
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL release_ready: in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      send_frame('{5, 6}, 1'b1, 0, 1'b1);
   endtask

   task automatic test_abort();
      put(4'd7, 1'b0);
      put(4'd7, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_flags: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      send_frame('{1, 1, 1, 1}, 1'b0, 0, 1'b1);
   endtask

   task automatic test_gaps();
      for (int r = 0; r < 3; r++) send_frame('{2, 4, 6, 8}, 1'b0, 3, 1'b1);
   endtask

   task automatic test_back_to_back();
      send_frame('{1, 2, 3, 4}, 1'b0, 0, 1'b1);
      send_frame('{9, 9, 9, 9}, 1'b0, 0, 1'b1);
   endtask

   task automatic test_drain();
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_early_last();
      test_backpressure();
      test_abort();
      test_gaps();
      test_back_to_back();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
